fft_mem_ctrl: RTL
=================

// Module: fft_mem_ctrl
// PURPOSE
//  Initiator/sequencer for the 8x8 base-8 FFT buffer: drives its 1x1 and 1x8 rd/wr ports.
//  Flow: load 64 serial samples (1x1 wr), then 8 row passes and 8 column passes (1x8 rd -> FFT8 engine -> 1x8 wr-back).
//  Then unloads 64 results serially (1x1 rd) through a back-pressured output stream.
// PARAMETERS
//  DATA_WD   20  width of one complex sample word
//  SIZE_MAT  8   matrix dimension, fixed; SIZE_MAT_WD=3, full size 64, full addr width 6
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      asynchronous, active-low reset
//  start_i        in   1      start one 64-pt transform; sampled in IDLE only
//  busy_o         out  1      high from start accept until done_o
//  done_o         out  1      1-cycle pulse after last output handshake
//  in_vld_i/in_rdy_o  in/out 1  input sample handshake; in_dat_i in DATA_WD
//  out_vld_o/out_rdy_i out/in 1 output sample handshake; out_dat_o out DATA_WD
//  dim_sel_o      out  1      0 row, 1 col; to buffer
//  rd_addr_1x8_o  out  3      row/col index; rd_vld_1x8_o out 1 read request
//  rd_vld_1x8_i   in   1      buffer read return, 1 cycle after request; rd_dat_1x8_i in 8*DATA_WD
//  wr_addr_1x8_o  out  3      ; wr_vld_1x8_o out 1; wr_dat_1x8_o out 8*DATA_WD
//  rd_addr_1x1_o  out  6      ; rd_vld_1x1_o out 1; rd_vld_1x1_i in 1; rd_dat_1x1_i in DATA_WD
//  wr_addr_1x1_o  out  6      ; wr_vld_1x1_o out 1; wr_dat_1x1_o out DATA_WD
//  eng_vld_o      out  1      1-cycle vector issue to FFT8 engine; eng_dat_o out 8*DATA_WD
//  eng_dim_o      out  1      pass type for twiddle select; eng_idx_o out 3 row/col index
//  eng_vld_i      in   1      engine result strobe, arbitrary latency >=1; eng_dat_i in 8*DATA_WD
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0, output buffer empty; mid-operation reset aborts to IDLE, no done_o.
//  FSM: IDLE -> LOAD -> PRD -> PMEM -> PENG -> PWR -> (PRD | UNLOAD) -> DONE -> IDLE.
//  IDLE: start_i=1 -> LOAD, busy_o=1, pass=row, idx=0. start_i outside IDLE ignored.
//  LOAD: in_rdy_o=1; each in_vld_i&in_rdy_o -> same-cycle wr_vld_1x1_o=1, addr=cnt, dat=in_dat_i; cnt 63 -> PRD.
//  PRD: rd_vld_1x8_o=1 for 1 cycle, addr=idx. PMEM: wait rd_vld_1x8_i, capture data, -> PENG.
//  PENG: on entry eng_vld_o=1 for 1 cycle with captured vector, eng_dim_o=pass, eng_idx_o=idx; wait eng_vld_i.
//  PWR: wr_vld_1x8_o=1 for 1 cycle, addr=idx, dat=engine result; idx 7: row->col pass (idx=0, PRD), col->UNLOAD; else idx+1.
//  dim_sel_o constant through a whole pass incl. write-back; changes only between passes.
//  Never asserts wr_vld_1x1_o and wr_vld_1x8_o in the same cycle; never more than one 1x8 read outstanding.
//  eng_vld_i outside PENG ignored.
//  UNLOAD: 2-entry output FIFO (sub-module); issue rd_vld_1x1_o when fifo_cnt + inflight < 2; full throughput 1/cycle.
//  rd_vld_1x1_i pushes rd_dat_1x1_i; out_vld_o = FIFO non-empty; data held stable while out_rdy_i=0.
//  After 64th output handshake -> DONE: done_o=1 one cycle, busy_o=0 same cycle, -> IDLE.
//  Counters 6-bit load/issue/pop, 3-bit idx; no wrap beyond terminal value.
// CONFIGURATION
//  FFT_MEM_CTRL_TRANSPOSE_EN defined: unload address k -> {k[2:0],k[5:3]} (column-major, natural FFT order).
//  Undefined: unload address = k (row-major, raw buffer order). Load order unaffected.
// STRUCTURE
//  fft_pkg: DATA_WD, SIZE_MAT, SIZE_MAT_WD, SIZE_MAT_FUL(_WD), FSM state localparams.
//  Sub-module fft_mem_ctrl_obuf: 2-entry skid FIFO with count output; rest in top.
// TESTING
//  Ramp 0..63, in_vld_i held, out_rdy_i=1, identity engine latency 3 -> wr_1x1 addr 0..63 in 64 cycles; outputs per macro order.
//  Row/col sequence: check 8 rd/wr 1x8 with dim_sel_o=0 idx 0..7, then 8 with dim_sel_o=1; no 1x1/1x8 write overlap.
//  out_rdy_i toggling 1010.. and 4-cycle stalls -> exactly 64 outputs, no loss/dup, data stable while stalled.
//  start_i pulsed during col pass -> ignored; single done_o after 64th output; busy_o low next cycle.
//  rst_n asserted during PENG of row 5 -> all outputs 0 immediately; fresh start completes normally.
//  TRANSPOSE_EN set, buffer word = address -> out_dat_o sequence 0,8,16,..,56,1,9,..; unset -> 0,1,2,..

Source files
------------

// File: rtl/fft_mem_ctrl_pkg.sv
// Shared types and constants for the 8x8 FFT buffer sequencer.
// Optional feature macro used by the top: FFT_MEM_CTRL_TRANSPOSE_EN.
package fft_mem_ctrl_pkg;

    localparam int DATA_WD         = 20;
    localparam int SIZE_MAT        = 8;
    localparam int SIZE_MAT_WD     = 3;
    localparam int SIZE_MAT_FUL    = SIZE_MAT * SIZE_MAT;
    localparam int SIZE_MAT_FUL_WD = 6;
    localparam int VEC_WD          = SIZE_MAT * DATA_WD;

    typedef logic [DATA_WD-1:0]         word_t;
    typedef logic [VEC_WD-1:0]          vec_t;
    typedef logic [SIZE_MAT_WD-1:0]     idx_t;
    typedef logic [SIZE_MAT_FUL_WD-1:0] addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRD,
        ST_PMEM,
        ST_PENG,
        ST_PWR,
        ST_UNLOAD,
        ST_DONE
    } state_t;

    typedef enum logic {
        DIM_ROW = 1'b0,
        DIM_COL = 1'b1
    } dim_t;

    localparam addr_t ADDR_LAST = addr_t'(SIZE_MAT_FUL - 1);
    localparam idx_t  IDX_LAST  = idx_t'(SIZE_MAT - 1);

    // Swap the row and column fields of a linear buffer address.
    function automatic addr_t transpose_addr(input addr_t k);
        return {k[2:0], k[5:3]};
    endfunction

endpackage

// File: rtl/fft_mem_ctrl_if.sv
// Bundle of all sample-stream, buffer-port and engine-port signals of the
// FFT buffer sequencer. master = sequencer side, slave = environment side.
interface fft_mem_ctrl_if;
    import fft_mem_ctrl_pkg::*;

    logic  start_i;
    logic  busy_o;
    logic  done_o;
    logic  in_vld_i;
    logic  in_rdy_o;
    word_t in_dat_i;
    logic  out_vld_o;
    logic  out_rdy_i;
    word_t out_dat_o;
    logic  dim_sel_o;
    idx_t  rd_addr_1x8_o;
    logic  rd_vld_1x8_o;
    logic  rd_vld_1x8_i;
    vec_t  rd_dat_1x8_i;
    idx_t  wr_addr_1x8_o;
    logic  wr_vld_1x8_o;
    vec_t  wr_dat_1x8_o;
    addr_t rd_addr_1x1_o;
    logic  rd_vld_1x1_o;
    logic  rd_vld_1x1_i;
    word_t rd_dat_1x1_i;
    addr_t wr_addr_1x1_o;
    logic  wr_vld_1x1_o;
    word_t wr_dat_1x1_o;
    logic  eng_vld_o;
    vec_t  eng_dat_o;
    logic  eng_dim_o;
    idx_t  eng_idx_o;
    logic  eng_vld_i;
    vec_t  eng_dat_i;

    modport master (
        input  start_i, in_vld_i, in_dat_i, out_rdy_i,
        input  rd_vld_1x8_i, rd_dat_1x8_i, rd_vld_1x1_i, rd_dat_1x1_i,
        input  eng_vld_i, eng_dat_i,
        output busy_o, done_o, in_rdy_o, out_vld_o, out_dat_o, dim_sel_o,
        output rd_addr_1x8_o, rd_vld_1x8_o, wr_addr_1x8_o, wr_vld_1x8_o, wr_dat_1x8_o,
        output rd_addr_1x1_o, rd_vld_1x1_o, wr_addr_1x1_o, wr_vld_1x1_o, wr_dat_1x1_o,
        output eng_vld_o, eng_dat_o, eng_dim_o, eng_idx_o
    );

    modport slave (
        output start_i, in_vld_i, in_dat_i, out_rdy_i,
        output rd_vld_1x8_i, rd_dat_1x8_i, rd_vld_1x1_i, rd_dat_1x1_i,
        output eng_vld_i, eng_dat_i,
        input  busy_o, done_o, in_rdy_o, out_vld_o, out_dat_o, dim_sel_o,
        input  rd_addr_1x8_o, rd_vld_1x8_o, wr_addr_1x8_o, wr_vld_1x8_o, wr_dat_1x8_o,
        input  rd_addr_1x1_o, rd_vld_1x1_o, wr_addr_1x1_o, wr_vld_1x1_o, wr_dat_1x1_o,
        input  eng_vld_o, eng_dat_o, eng_dim_o, eng_idx_o
    );

endinterface

// File: rtl/fft_mem_ctrl_obuf.sv
// Two-entry output skid FIFO with occupancy count. The head word reads as
// zero whenever the FIFO is empty.
module fft_mem_ctrl_obuf
    import fft_mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  word_t      push_dat,
    input  logic       pop,
    output word_t      pop_dat,
    output logic [1:0] cnt
);

    word_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;

    // Storage write; entries are only ever observed through a non-zero count.
    // NOTE: data storage has no reset; pointers and count carry all control state.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: clocked state uses non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign pop_dat = (cnt != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fft_mem_ctrl.sv
// Sequencer for the 8x8 base-8 FFT buffer: serial load, 8 row + 8 column
// FFT8 passes through the 1x8 ports, then serial back-pressured unload.
// Optional macro FFT_MEM_CTRL_TRANSPOSE_EN: unload in column-major order.
module fft_mem_ctrl
    import fft_mem_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    fft_mem_ctrl_if.master bus
);

    state_t     state_q, state_d;
    dim_t       dim_q;
    idx_t       idx_q;
    addr_t      ld_cnt_q;
    addr_t      iss_cnt_q;
    logic       iss_done_q;
    addr_t      pop_cnt_q;
    logic [1:0] infl_q;
    logic       eng_sent_q;
    vec_t       vec_q;
    vec_t       res_q;

    logic       in_hs;
    logic       eng_ret;
    logic       fifo_pop;
    logic       rd_ret;
    logic       unload_issue;
    logic [1:0] fifo_cnt;
    word_t      fifo_dat;
    addr_t      unload_addr;

`ifdef FFT_MEM_CTRL_TRANSPOSE_EN
    assign unload_addr = transpose_addr(iss_cnt_q);
`else
    assign unload_addr = iss_cnt_q;
`endif

    assign in_hs    = (state_q == ST_LOAD) && bus.in_vld_i;
    assign eng_ret  = (state_q == ST_PENG) && eng_sent_q && bus.eng_vld_i;
    assign fifo_pop = (fifo_cnt != 2'd0) && bus.out_rdy_i;
    assign rd_ret   = bus.rd_vld_1x1_i && (infl_q != 2'd0);
    // A word popped this cycle frees a slot, which keeps reads at one per cycle.
    assign unload_issue = (state_q == ST_UNLOAD) && !iss_done_q &&
                          (({1'b0, fifo_cnt} + {1'b0, infl_q}) < (3'd2 + {2'b0, fifo_pop}));

    fft_mem_ctrl_obuf u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rd_ret),
        .push_dat (bus.rd_dat_1x1_i),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .cnt      (fifo_cnt)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and all port outputs.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path infers a latch.
        state_d            = state_q;
        bus.busy_o         = (state_q != ST_IDLE) && (state_q != ST_DONE);
        bus.done_o         = (state_q == ST_DONE);
        bus.in_rdy_o       = 1'b0;
        bus.out_vld_o      = (fifo_cnt != 2'd0);
        bus.out_dat_o      = fifo_dat;
        bus.dim_sel_o      = 1'b0;
        bus.rd_addr_1x8_o  = '0;
        bus.rd_vld_1x8_o   = 1'b0;
        bus.wr_addr_1x8_o  = '0;
        bus.wr_vld_1x8_o   = 1'b0;
        bus.wr_dat_1x8_o   = '0;
        bus.rd_addr_1x1_o  = '0;
        bus.rd_vld_1x1_o   = 1'b0;
        bus.wr_addr_1x1_o  = '0;
        bus.wr_vld_1x1_o   = 1'b0;
        bus.wr_dat_1x1_o   = '0;
        bus.eng_vld_o      = 1'b0;
        bus.eng_dat_o      = '0;
        bus.eng_dim_o      = 1'b0;
        bus.eng_idx_o      = '0;
        case (state_q)
            ST_IDLE: if (bus.start_i) state_d = ST_LOAD;
            ST_LOAD: begin
                bus.in_rdy_o      = 1'b1;
                bus.wr_vld_1x1_o  = bus.in_vld_i;
                bus.wr_addr_1x1_o = ld_cnt_q;
                bus.wr_dat_1x1_o  = bus.in_dat_i;
                if (in_hs && ld_cnt_q == ADDR_LAST) state_d = ST_PRD;
            end
            ST_PRD: begin
                bus.dim_sel_o     = dim_q;
                bus.rd_vld_1x8_o  = 1'b1;
                bus.rd_addr_1x8_o = idx_q;
                state_d           = ST_PMEM;
            end
            ST_PMEM: begin
                bus.dim_sel_o = dim_q;
                if (bus.rd_vld_1x8_i) state_d = ST_PENG;
            end
            ST_PENG: begin
                bus.dim_sel_o = dim_q;
                bus.eng_vld_o = !eng_sent_q;
                bus.eng_dat_o = vec_q;
                bus.eng_dim_o = dim_q;
                bus.eng_idx_o = idx_q;
                if (eng_ret) state_d = ST_PWR;
            end
            ST_PWR: begin
                bus.dim_sel_o     = dim_q;
                bus.wr_vld_1x8_o  = 1'b1;
                bus.wr_addr_1x8_o = idx_q;
                bus.wr_dat_1x8_o  = res_q;
                if (idx_q == IDX_LAST && dim_q == DIM_COL) state_d = ST_UNLOAD;
                else                                       state_d = ST_PRD;
            end
            ST_UNLOAD: begin
                bus.rd_vld_1x1_o  = unload_issue;
                bus.rd_addr_1x1_o = unload_addr;
                if (fifo_pop && pop_cnt_q == ADDR_LAST) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Pass/index sequencing, vector capture and unload counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dim_q      <= DIM_ROW;
            idx_q      <= '0;
            ld_cnt_q   <= '0;
            iss_cnt_q  <= '0;
            iss_done_q <= 1'b0;
            pop_cnt_q  <= '0;
            infl_q     <= 2'd0;
            eng_sent_q <= 1'b0;
            vec_q      <= '0;
            res_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start_i) begin
                    dim_q      <= DIM_ROW;
                    idx_q      <= '0;
                    ld_cnt_q   <= '0;
                    iss_cnt_q  <= '0;
                    iss_done_q <= 1'b0;
                    pop_cnt_q  <= '0;
                end
                ST_LOAD: if (in_hs && ld_cnt_q != ADDR_LAST) ld_cnt_q <= ld_cnt_q + 1'b1;
                ST_PMEM: if (bus.rd_vld_1x8_i) vec_q <= bus.rd_dat_1x8_i;
                ST_PENG: begin
                    eng_sent_q <= 1'b1;
                    if (eng_ret) res_q <= bus.eng_dat_i;
                end
                ST_PWR: begin
                    eng_sent_q <= 1'b0;
                    if (idx_q != IDX_LAST) begin
                        idx_q <= idx_q + 1'b1;
                    end else if (dim_q == DIM_ROW) begin
                        dim_q <= DIM_COL;
                        idx_q <= '0;
                    end
                end
                default: ;
            endcase
            if (unload_issue) begin
                if (iss_cnt_q == ADDR_LAST) iss_done_q <= 1'b1;
                else                        iss_cnt_q  <= iss_cnt_q + 1'b1;
            end
            if (fifo_pop && pop_cnt_q != ADDR_LAST) pop_cnt_q <= pop_cnt_q + 1'b1;
            infl_q <= infl_q + {1'b0, unload_issue} - {1'b0, rd_ret};
        end
    end

endmodule
